// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - segment constants and width helper for the seven-segment scan manager
package ssd_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Never returns less than 1 so a single-digit build still gets a real index register.
  function automatic int ssd_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational hex digit to active-high {g..a} segment decoder
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_manager.sv
// rtl/ssd_scan_manager.sv - N-digit multiplexed seven-segment scanner with blanking and frame latching
// Leading-zero blanking is built in when SSD_SCAN_MANAGER_LZB_EN is defined.
module ssd_scan_manager
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int REFRESH_DIV      = 100_000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    ssd_scan_manager_clk,
  input  logic                    ssd_scan_manager_rst_n,
  input  logic [4*NUM_DIGITS-1:0] ssd_scan_manager_port_digits,
  input  logic [NUM_DIGITS-1:0]   ssd_scan_manager_port_digit_en,
  input  logic [NUM_DIGITS-1:0]   ssd_scan_manager_port_dp,
  output logic [6:0]              ssd_scan_manager_oport_cc,
  output logic                    ssd_scan_manager_oport_dp,
  output logic [NUM_DIGITS-1:0]   ssd_scan_manager_oport_anode_control,
  output logic                    ssd_scan_manager_oport_frame_tick
);

  localparam int IDX_W = ssd_clog2(NUM_DIGITS);
  localparam int PSC_W = ssd_clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            CC_OFF    = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

  logic [PSC_W-1:0]        psc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    frame_start;
  logic                    in_blank;
  logic [4*NUM_DIGITS-1:0] cur_digits;
  logic [NUM_DIGITS-1:0]   cur_en;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [NUM_DIGITS-1:0]   show;
  logic [NUM_DIGITS-1:0]   anode_on;
  logic [3:0]              sel_digit;
  logic                    sel_show;
  logic                    sel_dp;
  logic                    lit;
  logic [6:0]              seg_hi;

  assign frame_start = (psc == '0) && (idx == '0);
  assign in_blank    = int'(psc) < BLANK_CYCLES;

  // During the frame-start cycle the shadows are still being loaded, so bypass to the live inputs.
  assign cur_digits = frame_start ? ssd_scan_manager_port_digits   : shadow_digits;
  assign cur_en     = frame_start ? ssd_scan_manager_port_digit_en : shadow_en;
  assign cur_dp     = frame_start ? ssd_scan_manager_port_dp       : shadow_dp;

`ifdef SSD_SCAN_MANAGER_LZB_EN
  logic nz_seen;

  // Walk down from the top digit; everything above the highest nonzero digit is suppressed unless its dp is lit.
  always_comb begin
    show    = cur_en;
    nz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      nz_seen = nz_seen | (cur_digits[4*k +: 4] != 4'h0);
      if (!nz_seen && !cur_dp[k]) show[k] = 1'b0;
    end
  end
`else
  assign show = cur_en;
`endif

  always_comb begin
    sel_digit = 4'h0;
    sel_show  = 1'b0;
    sel_dp    = 1'b0;
    anode_on  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_digit   = cur_digits[4*k +: 4];
        sel_show    = show[k];
        sel_dp      = cur_dp[k];
        anode_on[k] = show[k] && !in_blank;
      end
    end
  end

  assign lit = sel_show && !in_blank;

  ssd_hex_decoder u_decoder (
    .digit (sel_digit),
    .seg   (seg_hi)
  );

  always_ff @(posedge ssd_scan_manager_clk) begin
    if (!ssd_scan_manager_rst_n) begin
      psc                                  <= '0;
      idx                                  <= '0;
      shadow_digits                        <= '0;
      shadow_en                            <= '0;
      shadow_dp                            <= '0;
      ssd_scan_manager_oport_cc            <= CC_OFF;
      ssd_scan_manager_oport_dp            <= DP_OFF;
      ssd_scan_manager_oport_anode_control <= ANODE_OFF;
      ssd_scan_manager_oport_frame_tick    <= 1'b0;
    end else begin
      ssd_scan_manager_oport_frame_tick <= frame_start;
      if (frame_start) begin
        shadow_digits <= ssd_scan_manager_port_digits;
        shadow_en     <= ssd_scan_manager_port_digit_en;
        shadow_dp     <= ssd_scan_manager_port_dp;
      end
      if (psc == PSC_W'(REFRESH_DIV - 1)) begin
        psc <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
      ssd_scan_manager_oport_anode_control <= (ANODE_ACTIVE_LOW != 0) ? ~anode_on : anode_on;
      ssd_scan_manager_oport_cc <= lit ? ((SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi) : CC_OFF;
      ssd_scan_manager_oport_dp <= (lit && sel_dp) ? ~DP_OFF : DP_OFF;
    end
  end

endmodule

// File: tb/tb_ssd_scan_manager.sv
// tb/tb_ssd_scan_manager.sv - scoreboard bench for ssd_scan_manager (4-digit main instance plus 1-digit instance)
module tb_ssd_scan_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  en;
  logic [3:0]  dp;

  logic [6:0]  cc;
  logic        dpo;
  logic [3:0]  anode;
  logic        tick;

  logic [6:0]  cc1;
  logic        dpo1;
  logic [0:0]  anode1;
  logic        tick1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int one_phase = 0;
  logic [12:0] exp_q[$];
  logic [6:0]  seg_tab [16];

  localparam logic [12:0] RESET_EXP = {1'b0, 4'hF, 7'h7F, 1'b1};

  always #5 clk = ~clk;

  ssd_scan_manager #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .ssd_scan_manager_clk                 (clk),
    .ssd_scan_manager_rst_n               (rst_n),
    .ssd_scan_manager_port_digits         (digits),
    .ssd_scan_manager_port_digit_en       (en),
    .ssd_scan_manager_port_dp             (dp),
    .ssd_scan_manager_oport_cc            (cc),
    .ssd_scan_manager_oport_dp            (dpo),
    .ssd_scan_manager_oport_anode_control (anode),
    .ssd_scan_manager_oport_frame_tick    (tick)
  );

  ssd_scan_manager #(
    .NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_one (
    .ssd_scan_manager_clk                 (clk),
    .ssd_scan_manager_rst_n               (rst_n),
    .ssd_scan_manager_port_digits         (4'h8),
    .ssd_scan_manager_port_digit_en       (1'b1),
    .ssd_scan_manager_port_dp             (1'b1),
    .ssd_scan_manager_oport_cc            (cc1),
    .ssd_scan_manager_oport_dp            (dpo1),
    .ssd_scan_manager_oport_anode_control (anode1),
    .ssd_scan_manager_oport_frame_tick    (tick1)
  );

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cycle, obs, expv);
    end
  endtask

  // Expected {tick, anode, cc, dp} per cycle of one frame; the first 'count' cycles are queued.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p, input int count);
    logic [3:0]  shown;
    logic [12:0] ent;
    int n;
    int hi;
    shown = e;
    n = 0;
    hi = 0;
`ifdef SSD_SCAN_MANAGER_LZB_EN
    for (int k = 0; k < 4; k++) if (d[4*k +: 4] != 4'h0) hi = k;
    for (int k = 1; k < 4; k++) if (k > hi && !p[k]) shown[k] = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 8; s++) begin
        if (n < count) begin
          if (s < 2 || !shown[k]) ent = {(k == 0 && s == 0), 4'hF, 7'h7F, 1'b1};
          else ent = {1'b0, ~(4'b0001 << k), ~seg_tab[d[4*k +: 4]], ~p[k]};
          exp_q.push_back(ent);
        end
        n++;
      end
    end
  endtask

  task automatic step(input int n);
    logic [12:0] e;
    logic        r;
    for (int i = 0; i < n; i++) begin
      r = rst_n;
      @(posedge clk);
      @(negedge clk);
      cycle++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty cycle %0d observed output with no expectation", cycle);
      end else begin
        e = exp_q.pop_front();
        check("main_outputs", {tick, anode, cc, dpo}, e);
      end
      if (!r) begin
        one_phase = 0;
        check("one_digit_reset", {tick1, anode1, cc1, dpo1}, {1'b0, 1'b0, 7'h00, 1'b0});
      end else begin
        if (one_phase == 0) check("one_digit_blank", {tick1, anode1, cc1, dpo1}, {1'b1, 1'b0, 7'h00, 1'b0});
        else check("one_digit_lit", {tick1, anode1, cc1, dpo1}, {1'b0, 1'b1, 7'h7F, 1'b1});
        one_phase = (one_phase + 1) % 4;
      end
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      digits = 16'($urandom);
      en     = 4'($urandom);
      dp     = 4'($urandom);
      exp_q.push_back(RESET_EXP);
      step(1);
    end

    digits = 16'h4321; en = 4'hF; dp = 4'b0010; rst_n = 1'b1;
    push_frame(16'h4321, 4'hF, 4'b0010, 32);
    push_frame(16'h4321, 4'hF, 4'b0010, 32);
    step(64);

    push_frame(16'h4321, 4'hF, 4'b0010, 32);
    step(19);
    digits = 16'h9999;
    step(13);
    push_frame(16'h9999, 4'hF, 4'b0010, 32);
    step(32);

    en = 4'b0101;
    push_frame(16'h9999, 4'b0101, 4'b0010, 32);
    step(32);

    digits = 16'h4321; en = 4'hF;
    push_frame(16'h4321, 4'hF, 4'b0010, 19);
    step(19);
    rst_n = 1'b0;
    exp_q.push_back(RESET_EXP);
    step(1);
    rst_n = 1'b1;
    push_frame(16'h4321, 4'hF, 4'b0010, 32);
    step(32);

    digits = 16'h0005; en = 4'hF; dp = 4'b0000;
    push_frame(16'h0005, 4'hF, 4'b0000, 32);
    push_frame(16'h0005, 4'hF, 4'b0000, 32);
    step(64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
